// File: rtl/arb_pkg.sv
// Shared types and default sizing for the resource arbiter.
// The state encoding is exposed so checkers can bind to the FSM debug output.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_GRANT  = 2'd2,
    ST_REVOKE = 2'd3
  } ty_STATE_ARB;

  localparam int ARB_N_REQ_DEF    = 4;
  localparam int ARB_MAX_HOLD_DEF = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward
// from the slot after the last winner, wrapping at N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  always_comb begin
    int cand;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    cand  = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(i_last) + i) % N_REQ;
      if (!o_any && i_req[cand]) begin
        o_any       = 1'b1;
        o_idx       = IW'(cand);
        o_gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/resource_arbiter.sv
// Round-robin single-owner resource arbiter with forced revoke when an owner
// keeps the resource too long while others are waiting.
module resource_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = ARB_N_REQ_DEF,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
  input  logic                     i_ck,
  input  logic                     i_arst_n,
  input  logic [N_REQ-1:0]         i_req,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [$clog2(N_REQ)-1:0] o_gnt_id,
  output logic                     o_revoke,
  output logic                     o_busy,
  output logic [1:0]               o_dbg_state
);

  // Handshake: i_req is a level held by each requester until it is granted
  // and has finished; the owner releases by dropping its i_req bit, and
  // o_revoke is a request (not a command) for the owner to do so.

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST_RST  = IW'(N_REQ - 1);

  ty_STATE_ARB      state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    id_q, id_d;
  logic             rev_q, rev_d;
  logic             busy_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    last_q, last_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             owner_req;
  logic             rival_req;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .i_req  (i_req),
    .i_last (last_q),
    .o_gnt  (pick_gnt),
    .o_idx  (pick_idx),
    .o_any  (pick_any)
  );

  assign owner_req = |(i_req & gnt_q);
  assign rival_req = |(i_req & ~gnt_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    rev_d   = rev_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|i_req) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          gnt_d   = pick_gnt;
          id_d    = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // Owner release takes priority over a revoke due on the same edge.
        if (!owner_req) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          id_d    = '0;
        end else if (cnt_q == HOLD_LAST && rival_req) begin
          state_d = ST_REVOKE;
          rev_d   = 1'b1;
        end else if (cnt_q != HOLD_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REVOKE: begin
        if (!owner_req) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          id_d    = '0;
          rev_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_ck or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      rev_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      rev_q   <= rev_d;
      busy_q  <= (state_d != ST_IDLE);
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_gnt_id    = id_q;
  assign o_revoke    = rev_q;
  assign o_busy      = busy_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_resource_arbiter.sv
// Bench for resource_arbiter: directed scenarios plus randomized traffic,
// scored against a behavioural owner/hold-time model.
module tb_resource_arbiter;
  import arb_pkg::*;

  localparam int N  = 4;
  localparam int MH = 16;
  localparam int IW = $clog2(N);

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  o_gnt;
  logic [IW-1:0] o_gnt_id;
  logic          o_revoke;
  logic          o_busy;
  logic [1:0]    o_dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] rev_q[$];

  int m_owner;
  int m_last;
  int m_held;
  bit m_arb;
  bit m_rev;

  resource_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .i_ck        (clk),
    .i_arst_n    (rst_n),
    .i_req       (req),
    .o_gnt       (o_gnt),
    .o_gnt_id    (o_gnt_id),
    .o_revoke    (o_revoke),
    .o_busy      (o_busy),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick(2);
    chk("rst_gnt", int'(o_gnt), 0);
    chk("rst_gnt_id", int'(o_gnt_id), 0);
    chk("rst_revoke", int'(o_revoke), 0);
    chk("rst_busy", int'(o_busy), 0);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_gnt(input string name, output int id);
    int n;
    n  = 0;
    id = -1;
    while (o_gnt == '0 && n < 20) begin
      tick(1);
      n++;
    end
    if (o_gnt == '0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_grant expected=grant within 20 cycles", name);
    end else begin
      id = int'(o_gnt_id);
    end
  endtask

  // reference model: one owner at a time, round-robin choice, hold time in cycles
  initial begin
    logic [N-1:0] rivals;
    bit found;
    int c;
    m_owner = -1; m_arb = 0; m_rev = 0; m_held = 0; m_last = N - 1;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_owner = -1; m_arb = 0; m_rev = 0; m_held = 0; m_last = N - 1;
        exp_q.delete();
        rev_q.delete();
      end else if (m_owner < 0) begin
        if (m_arb) begin
          m_arb = 0;
          found = 0;
          for (int s = 1; s <= N; s++) begin
            c = (m_last + s) % N;
            if (!found && req[c]) begin
              found   = 1;
              m_owner = c;
            end
          end
          if (found) begin
            m_last = m_owner;
            m_held = 1;
            exp_q.push_back(IW'(m_owner));
          end
        end else if (req != '0) begin
          m_arb = 1;
        end
      end else begin
        rivals = req;
        rivals[m_owner] = 1'b0;
        if (!req[m_owner]) begin
          m_owner = -1;
          m_rev   = 0;
        end else if (!m_rev && m_held >= MH && rivals != '0) begin
          m_rev = 1;
          rev_q.push_back(IW'(m_owner));
        end else begin
          m_held++;
        end
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [N-1:0]  prev_gnt;
    logic          prev_rev;
    logic [IW-1:0] e;
    int exp_gnt;
    prev_gnt = '0;
    prev_rev = 1'b0;
    forever begin
      @(negedge clk);
      exp_gnt = (m_owner >= 0) ? (1 << m_owner) : 0;
      chk("cyc_gnt", int'(o_gnt), exp_gnt);
      chk("cyc_revoke", int'(o_revoke), int'(m_rev));
      chk("cyc_busy", int'(o_busy), int'(m_owner >= 0 || m_arb));
      if (o_gnt != '0 && prev_gnt == '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_grant actual=id%0d expected=no_grant", o_gnt_id);
        end else begin
          e = exp_q.pop_front();
          chk("sb_grant_id", int'(o_gnt_id), int'(e));
          chk("sb_grant_onehot", int'(o_gnt), 1 << e);
        end
      end
      if (o_revoke && !prev_rev) begin
        if (rev_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_revoke actual=revoke expected=no_revoke");
        end else begin
          e = rev_q.pop_front();
          chk("sb_revoke_owner", int'(o_gnt_id), int'(e));
        end
      end
      prev_gnt = o_gnt;
      prev_rev = o_revoke;
    end
  end

  // stimulus
  initial begin
    int id;
    int n;
    int order[5];
    order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    req   = '0;

    // single requester latency
    do_reset();
    req = 4'b0001;
    tick(1);
    chk("lat_busy_edge0", int'(o_busy), 1);
    chk("lat_gnt_edge0", int'(o_gnt), 0);
    tick(1);
    chk("lat_gnt_edge1", int'(o_gnt), 1);
    chk("lat_id_edge1", int'(o_gnt_id), 0);
    req = '0;
    tick(3);

    // full contention rotation
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("rr", id);
      chk($sformatf("rr_order%0d", k), id, order[k]);
      if (id >= 0) begin
        tick(3);
        req[id] = 1'b0;
        tick(1);
        req[id] = 1'b1;
      end
    end

    // forced revoke
    do_reset();
    req = 4'b0100;
    wait_gnt("rv", id);
    chk("rv_owner", id, 2);
    req = 4'b0101;
    n = 0;
    while (!o_revoke && n < 40) begin
      n++;
      tick(1);
    end
    chk("rv_grant_cycles", n, 16);
    tick(3);
    chk("rv_gnt_held", int'(o_gnt), 4);
    chk("rv_revoke_held", int'(o_revoke), 1);
    req = 4'b0001;
    tick(1);
    chk("rv_rel_gnt", int'(o_gnt), 0);
    chk("rv_rel_revoke", int'(o_revoke), 0);
    chk("rv_rel_state", int'(o_dbg_state), int'(ST_IDLE));
    tick(1);
    chk("rv_arb_state", int'(o_dbg_state), int'(ST_ARB));
    tick(1);
    chk("rv_next_gnt", int'(o_gnt), 1);
    chk("rv_next_id", int'(o_gnt_id), 0);

    // release on the same edge the revoke would fire
    do_reset();
    req = 4'b0100;
    wait_gnt("race", id);
    req = 4'b0101;
    tick(15);
    req = 4'b0001;
    tick(1);
    chk("race_revoke", int'(o_revoke), 0);
    chk("race_gnt", int'(o_gnt), 0);
    chk("race_state", int'(o_dbg_state), int'(ST_IDLE));
    tick(1);
    chk("race_revoke2", int'(o_revoke), 0);

    // one-cycle pulse in IDLE
    do_reset();
    req = 4'b0010;
    tick(1);
    req = '0;
    chk("pulse_busy", int'(o_busy), 1);
    tick(1);
    chk("pulse_busy_after", int'(o_busy), 0);
    chk("pulse_state", int'(o_dbg_state), int'(ST_IDLE));
    tick(2);
    chk("pulse_gnt", int'(o_gnt), 0);

    // asynchronous reset mid-grant
    do_reset();
    req = 4'b0001;
    wait_gnt("ar", id);
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt", int'(o_gnt), 0);
    chk("ar_id", int'(o_gnt_id), 0);
    chk("ar_revoke", int'(o_revoke), 0);
    chk("ar_busy", int'(o_busy), 0);
    req = 4'b1100;
    tick(2);
    rst_n = 1'b1;
    wait_gnt("ar_post", id);
    chk("ar_post_id", id, 2);
    req = '0;
    tick(3);

    // randomized traffic
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 5) == 0) req[i] = 1'b1;
        end else if (o_gnt[i]) begin
          if (o_revoke) begin
            if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
          end else if ($urandom_range(0, 13) == 0) begin
            req[i] = 1'b0;
          end
        end
      end
      tick(1);
    end
    req = '0;
    tick(5);
    chk("drain_exp_q", exp_q.size(), 0);
    chk("drain_rev_q", rev_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
